// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEF
);
    // A byte moves on a rising edge exactly when in_valid and in_ready are both 1;
    // in_ready never depends combinationally on in_valid, and the source may drop
    // in_valid for any number of cycles without timing out the loader.
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, error
    );

endinterface

// File: rtl/word_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid_o pulses the cycle after the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  lane_q;
    logic [23:0] part_q;
    logic [31:0] word_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q  <= 2'd0;
            part_q  <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            lane_q  <= 2'd0;
            part_q  <= 24'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_valid_i) begin
                if (lane_q == 2'd3) begin
                    word_q  <= {byte_i, part_q};
                    valid_q <= 1'b1;
                end else begin
                    part_q[8*lane_q +: 8] <= byte_i;
                end
                lane_q <= lane_q + 2'd1;
            end
        end
    end

    assign lane_o       = lane_q;
    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the core in reset until a load completes with a good checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output state_e        state_o
);

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d, len_v;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              last_q, last_d;
    logic              ready_q, done_q, error_q, crst_n_q;

    logic              accept, clear, pack_valid, last_word;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic              word_valid;

    assign accept     = bus.in_valid && ready_q;
    assign clear      = bus.start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign pack_valid = accept && (state_q == ST_DATA);
    assign len_v      = {bus.in_data, n_q[7:0]};
    assign last_word  = (16'(addr_q) + 16'd1) == n_q;

    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .byte_valid_i (pack_valid),
        .byte_i       (bus.in_data),
        .lane_o       (lane),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    state_d = ST_LEN0;
                    n_d     = 16'd0;
                    addr_d  = '0;
                    csum_d  = 8'd0;
                    last_d  = 1'b0;
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    n_d     = {8'd0, bus.in_data};
                    state_d = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    n_d = len_v;
                    if (len_v > 16'(DEPTH))   state_d = ST_ERR;
                    else if (len_v == 16'd0) state_d = ST_CHECK;
                    else                     state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.in_data;
                    if (lane == 2'd3 && last_word) last_d = 1'b1;
                end
                // The final write leaves DATA without advancing, keeping mem_addr at N-1.
                if (word_valid) begin
                    if (last_q) begin
                        state_d = ST_CHECK;
                        last_d  = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (accept) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready stays low while the last word is being written so the checksum
    // byte cannot slip in alongside that write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            n_q      <= 16'd0;
            addr_q   <= '0;
            csum_q   <= 8'd0;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            crst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
            csum_q   <= csum_d;
            last_q   <= last_d;
            ready_q  <= !last_d && (state_d == ST_LEN0 || state_d == ST_LEN1 ||
                                    state_d == ST_DATA || state_d == ST_CHECK);
            done_q   <= (state_d == ST_DONE);
            error_q  <= (state_d == ST_ERR);
            crst_n_q <= (state_d == ST_DONE);
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.mem_we     = word_valid;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = word;
    assign bus.core_rst_n = crst_n_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign state_o        = state_q;

endmodule
